system_dumper: RTL and testbench
================================

SYSTEM_DUMPER -- requirements
Module: system_dumper

Interface
REQ-001 Parameter ACC_LAT, default 2, memory access cycles per word (legal range 1..15).
REQ-002 Parameter DUMP_WORDS, default 1024, number of words read back after halt (legal range 1..2^30).
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle pulse that begins a load/run/dump sequence.
REQ-006 prog_valid / prog_data[31:0] / prog_last  in  1/32/1  program word stream; prog_last marks the final word.
REQ-007 prog_ready  out  1  program word accepted when prog_valid && prog_ready.
REQ-008 halt / load[31:0]  in  1/32  from the system side: CPU halted; memory read data.
REQ-009 tbCTRL / WEN / REN  out  1/1/1  system bus control: testbench owns memory; write enable; read enable.
REQ-010 addr / store  out  32/32  byte address and write data.
REQ-011 dump_valid / dump_addr[31:0] / dump_data[31:0]  out  dump stream.
REQ-012 dump_ready  in  1  dump word consumed when dump_valid && dump_ready.
REQ-013 done  out  1  sequence complete.

Function
REQ-014 States: IDLE, LOAD, LOAD_WR, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-015 IDLE: tbCTRL=1, WEN=REN=0; start moves to LOAD with load_ptr=0 and dump_ptr=0.
REQ-016 LOAD: prog_ready=1, tbCTRL=1; on handshake, capture prog_data and prog_last, then go to LOAD_WR.
REQ-017 LOAD_WR: prog_ready=0, WEN=1, addr=load_ptr, store=captured word, all held exactly ACC_LAT cycles.
REQ-018 Leaving LOAD_WR: load_ptr += 4; next state is RUN if the captured last flag was set, else LOAD.
REQ-019 RUN: tbCTRL=0, WEN=REN=0; halt=1 sampled here moves to DUMP_RD; halt is ignored in every other state.
REQ-020 DUMP_RD: tbCTRL=1, REN=1, addr=dump_ptr for ACC_LAT cycles; load is captured on the final cycle.
REQ-021 DUMP_OUT: REN=0, dump_valid=1, dump_addr=dump_ptr, dump_data=captured word.
REQ-022 DUMP_OUT: outputs held stable until dump_ready; dump_ready may be high in the first DUMP_OUT cycle.
REQ-023 After each dump word: dump_ptr += 4; after DUMP_WORDS words go to DONE, else back to DUMP_RD.
REQ-024 DONE: done=1, tbCTRL=1; start returns to LOAD with both pointers cleared, and done drops the next cycle.
REQ-025 start outside IDLE and DONE is ignored.
REQ-026 prog_valid outside LOAD is not accepted, and prog_ready=0 there.
REQ-027 WEN and REN are never both 1, and neither is 1 while tbCTRL=0.
REQ-028 Pointers are 32-bit and wrap modulo 2^32; no error is flagged on wrap.
REQ-029 Access cycles are counted by a 4-bit counter cleared on each state entry.

Reset
REQ-030 nRST low forces state IDLE with tbCTRL=1, and WEN=REN=0, addr=0, store=0.
REQ-031 nRST low also forces prog_ready=0, dump_valid=0, dump_addr=0, dump_data=0, done=0, pointers=0, counter=0.
REQ-032 Reset asserted mid-write or mid-dump aborts immediately; no partial word is emitted after reset release.

Configuration
REQ-033 Macro DUMP_SKIP_ZERO_EN, when defined: a captured read word equal to 0 is not presented on the dump stream.
REQ-034 With DUMP_SKIP_ZERO_EN, a zero word still advances dump_ptr and still counts toward DUMP_WORDS.
REQ-035 With DUMP_SKIP_ZERO_EN, after the last counted word (zero or not) the block enters DONE.
REQ-036 Without DUMP_SKIP_ZERO_EN, every word is presented, so exactly DUMP_WORDS handshakes occur.

Structure
REQ-037 word_t (32-bit), the dumper_state_t enum and the constant WBYTES=4 are defined in cpu_types_pkg.
REQ-038 ACC_LAT cycle counting is a sub-module, system_access_timer (start pulse in, expire pulse out).

Verification
REQ-039 Load: start, 3 words 0xA,0xB,0xC with prog_last on 0xC, ACC_LAT=2 -> WEN for 2 cycles each at addr 0,4,8; then RUN with tbCTRL=0.
REQ-040 Dump: halt=1 in RUN, load returns addr value, DUMP_WORDS=4, dump_ready=1 -> dump_addr 0,4,8,12 with matching data; then done=1.
REQ-041 Backpressure: dump_ready low for 5 cycles -> dump_valid, dump_addr and dump_data stable; no extra REN until the handshake.
REQ-042 Reset abort: nRST pulsed during LOAD_WR of the 2nd word -> all outputs reach reset values asynchronously; start restarts at addr 0.
REQ-043 Ignored events: halt=1 during LOAD and start during RUN -> no state change.
REQ-044 Skip-zero: with DUMP_SKIP_ZERO_EN, memory words {5,0,0,7}, DUMP_WORDS=4 -> exactly 2 handshakes (addr 0, addr 12), then done=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the system dumper: word type, dumper FSM states and word size.
package cpu_types_pkg;

  localparam int WBYTES = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_WR,
    RUN,
    DUMP_RD,
    DUMP_OUT,
    DONE
  } dumper_state_t;

  function automatic word_t next_ptr(input word_t ptr);
    return ptr + word_t'(WBYTES);
  endfunction

endpackage

// File: rtl/system_access_timer.sv
// Memory access timer: a start pulse arms a 4-bit counter and expire fires
// in the ACC_LAT-th cycle after the start edge.
module system_access_timer #(
  parameter int ACC_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expire
);

  localparam logic [3:0] LAST = 4'(ACC_LAT - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       active_q, active_d;

  assign expire = active_q && (cnt_q == LAST);

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (expire) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/system_dumper.sv
// Loads a program into system memory, lets the CPU run until halt, then dumps
// DUMP_WORDS words. Optional macro DUMP_SKIP_ZERO_EN suppresses zero words on the dump stream.
module system_dumper
  import cpu_types_pkg::*;
#(
  parameter int ACC_LAT    = 2,
  parameter int DUMP_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        prog_valid,
  input  logic [31:0] prog_data,
  input  logic        prog_last,
  output logic        prog_ready,
  input  logic        halt,
  input  logic [31:0] load,
  output logic        tbCTRL,
  output logic        WEN,
  output logic        REN,
  output logic [31:0] addr,
  output logic [31:0] store,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  input  logic        dump_ready,
  output logic        done
);

  localparam logic [30:0] LAST_WORD = 31'(DUMP_WORDS - 1);

  dumper_state_t state_q, state_d;
  word_t         load_ptr_q, load_ptr_d;
  word_t         dump_ptr_q, dump_ptr_d;
  word_t         wdata_q, wdata_d;
  word_t         rdata_q, rdata_d;
  logic          last_q, last_d;
  logic [30:0]   word_cnt_q, word_cnt_d;
  logic          timer_start;
  logic          acc_expire;
  logic          word_done;

  system_access_timer #(.ACC_LAT(ACC_LAT)) u_timer (
    .clk    (CLK),
    .rst_n  (nRST),
    .start  (timer_start),
    .expire (acc_expire)
  );

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    dump_ptr_d = dump_ptr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    word_done  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          load_ptr_d = '0;
          dump_ptr_d = '0;
          word_cnt_d = '0;
        end
      end
      LOAD: begin
        if (prog_valid) begin
          wdata_d = prog_data;
          last_d  = prog_last;
          state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        if (acc_expire) begin
          load_ptr_d = next_ptr(load_ptr_q);
          state_d    = last_q ? RUN : LOAD;
        end
      end
      RUN: begin
        if (halt) state_d = DUMP_RD;
      end
      DUMP_RD: begin
        if (acc_expire) begin
          rdata_d = load;
`ifdef DUMP_SKIP_ZERO_EN
          if (load == '0) word_done = 1'b1;
          else            state_d   = DUMP_OUT;
`else
          state_d = DUMP_OUT;
`endif
        end
      end
      DUMP_OUT: begin
        if (dump_ready) word_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A finished word (presented or skipped) advances the dump and may end it.
    if (word_done) begin
      dump_ptr_d = next_ptr(dump_ptr_q);
      word_cnt_d = word_cnt_q + 31'd1;
      state_d    = (word_cnt_q == LAST_WORD) ? DONE : DUMP_RD;
    end

    // A skipped word re-enters DUMP_RD, which also needs a fresh access count.
    timer_start = (state_d != state_q) || word_done;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      load_ptr_q <= '0;
      dump_ptr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      last_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      dump_ptr_q <= dump_ptr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    tbCTRL     = (state_q != RUN);
    WEN        = (state_q == LOAD_WR);
    REN        = (state_q == DUMP_RD);
    prog_ready = (state_q == LOAD);
    dump_valid = (state_q == DUMP_OUT);
    done       = (state_q == DONE);
    addr       = '0;
    store      = '0;
    dump_addr  = '0;
    dump_data  = '0;
    if (WEN) begin
      addr  = load_ptr_q;
      store = wdata_q;
    end
    if (REN) addr = dump_ptr_q;
    if (dump_valid) begin
      dump_addr = dump_ptr_q;
      dump_data = rdata_q;
    end
  end

endmodule

// File: tb/tb_system_dumper.sv
// Scoreboard bench for system_dumper: random programs and memory contents checked
// against a word-level memory model; honours DUMP_SKIP_ZERO_EN when defined.
module tb_system_dumper;
  import cpu_types_pkg::*;

  localparam int ACC_LAT    = 2;
  localparam int DUMP_WORDS = 4;
  localparam int MEM_WORDS  = 64;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, prog_valid, prog_last, prog_ready;
  logic [31:0] prog_data;
  logic        halt;
  logic [31:0] load;
  logic        tbCTRL, WEN, REN;
  logic [31:0] addr, store;
  logic        dump_valid, dump_ready, done;
  logic [31:0] dump_addr, dump_data;

  system_dumper #(.ACC_LAT(ACC_LAT), .DUMP_WORDS(DUMP_WORDS)) dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
    .halt(halt), .load(load), .tbCTRL(tbCTRL), .WEN(WEN), .REN(REN),
    .addr(addr), .store(store),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_ready(dump_ready), .done(done)
  );

  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sys_mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  xfer_t       wr_q[$];
  xfer_t       dump_q[$];
  int          ren_cycles = 0;
  int          force_low = 0;

  // System-side memory: written through the bus, read combinationally while REN.
  always @(posedge CLK) begin
    if (nRST && WEN) sys_mem[addr[7:2]] <= store;
  end

  always_comb begin
    load = 32'hBAD0_0BAD;
    if (REN) load = sys_mem[addr[7:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    checkOutput("rst_tbctrl", 32'(tbCTRL), 32'd1);
    checkOutput("rst_wen", 32'(WEN), 32'd0);
    checkOutput("rst_ren", 32'(REN), 32'd0);
    checkOutput("rst_addr", addr, 32'd0);
    checkOutput("rst_store", store, 32'd0);
    checkOutput("rst_prog_ready", 32'(prog_ready), 32'd0);
    checkOutput("rst_dump_valid", 32'(dump_valid), 32'd0);
    checkOutput("rst_dump_addr", dump_addr, 32'd0);
    checkOutput("rst_dump_data", dump_data, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
  endtask

  // Bus monitor: write runs, dump handshakes, stall stability and bus invariants.
  initial begin : monitor
    bit          in_run = 0;
    int          run_len = 0;
    logic [31:0] run_addr = 0, run_data = 0;
    bit          prev_stall = 0;
    logic [31:0] stall_addr = 0, stall_data = 0;
    xfer_t       e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        in_run = 0;
        prev_stall = 0;
        continue;
      end
      if ((WEN && REN) || ((WEN || REN) && !tbCTRL)) begin
        miscompares++;
        $display("[TB] FAIL bus_ctrl: got WEN=%0b REN=%0b tbCTRL=%0b", WEN, REN, tbCTRL);
      end
      if (REN) ren_cycles++;
      if (WEN) begin
        if (!in_run) begin
          in_run = 1; run_len = 1; run_addr = addr; run_data = store;
        end else begin
          checkOutput("wr_hold_addr", addr, run_addr);
          checkOutput("wr_hold_data", store, run_data);
          run_len++;
        end
      end else if (in_run) begin
        in_run = 0;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h expected none", run_addr);
        end else begin
          e = wr_q.pop_front();
          checkOutput("wr_addr", run_addr, e.a);
          checkOutput("wr_data", run_data, e.d);
          checkOutput("wr_len", 32'(run_len), 32'(ACC_LAT));
        end
      end
      if (dump_valid && prev_stall) begin
        checkOutput("stall_addr", dump_addr, stall_addr);
        checkOutput("stall_data", dump_data, stall_data);
      end
      prev_stall = dump_valid && !dump_ready;
      stall_addr = dump_addr;
      stall_data = dump_data;
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_dump: got addr 0x%08h expected none", dump_addr);
        end else begin
          e = dump_q.pop_front();
          checkOutput("dump_addr", dump_addr, e.a);
          checkOutput("dump_data", dump_data, e.d);
        end
      end
    end
  end

  initial begin : ready_driver
    dump_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (force_low > 0) begin
        dump_ready = 1'b0;
        if (dump_valid) force_low--;
      end else begin
        dump_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [31:0] d, input bit last, input bit expect_wr);
    bit got = 0;
    int gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge CLK); #1; end
    if (expect_wr) begin
      wr_q.push_back('{a: 32'(idx * WBYTES), d: d});
      ref_mem[idx] = d;
    end
    prog_data = d; prog_last = last; prog_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (prog_ready) begin got = 1; break; end
    end
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL prog_handshake_timeout: got no prog_ready expected handshake");
    end
    @(posedge CLK); #1 prog_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] words[$], input bit extras, input int bp);
    bit reached = 0;
    ren_cycles = 0;
    pulse_start();
    if (extras) begin
      halt = 1'b1;
      repeat (3) begin
        @(negedge CLK);
        checkOutput("halt_in_load_ready", 32'(prog_ready), 32'd1);
        checkOutput("halt_in_load_ren", 32'(REN), 32'd0);
      end
      @(posedge CLK); #1 halt = 1'b0;
    end
    foreach (words[i]) send_word(i, words[i], i == words.size() - 1, 1);
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!tbCTRL) begin reached = 1; break; end
    end
    checkOutput("run_reached", 32'(reached), 32'd1);
    checkOutput("run_tbctrl", 32'(tbCTRL), 32'd0);
    if (extras) begin
      pulse_start();
      @(negedge CLK);
      checkOutput("start_in_run_tbctrl", 32'(tbCTRL), 32'd0);
      checkOutput("start_in_run_ready", 32'(prog_ready), 32'd0);
    end
    for (int i = 0; i < DUMP_WORDS; i++) begin
`ifdef DUMP_SKIP_ZERO_EN
      if (ref_mem[i] != 32'd0)
`endif
        dump_q.push_back('{a: 32'(i * WBYTES), d: ref_mem[i]});
    end
    force_low = bp;
    @(posedge CLK); #1 halt = 1'b1;
    @(posedge CLK); #1 halt = 1'b0;
    reached = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge CLK);
      if (done) begin reached = 1; break; end
    end
    checkOutput("done", 32'(reached), 32'd1);
    checkOutput("dump_left", 32'(dump_q.size()), 32'd0);
    checkOutput("wr_left", 32'(wr_q.size()), 32'd0);
    checkOutput("ren_cycles", 32'(ren_cycles), 32'(ACC_LAT * DUMP_WORDS));
    dump_q.delete();
    wr_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin : main
    logic [31:0] words[$];
    for (int i = 0; i < MEM_WORDS; i++) begin
      sys_mem[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ref_mem[i] = sys_mem[i];
    end
    nRST = 1'b0; start = 1'b0; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0; halt = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(negedge CLK);
    nRST = 1'b1;

    words = '{32'hA, 32'hB, 32'hC};
    applyStimulus(words, 1, 5);

    // Abort the second program word mid-write, then restart from address 0.
    pulse_start();
    send_word(0, 32'h1111_0001, 1'b0, 1);
    send_word(1, 32'h2222_0002, 1'b0, 0);
    #2;
    checkOutput("wen_before_abort", 32'(WEN), 32'd1);
    nRST = 1'b0;
    #1;
    check_reset_values();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    wr_q.delete();
    dump_q.delete();

    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 6);
      words.delete();
      for (int k = 0; k < n; k++)
        words.push_back(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      applyStimulus(words, 0, ($urandom_range(0, 1) == 1) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
